// File: rtl/reg_sort_sequencer_if.sv
// Bus bundle between the sort sequencer and the three shared registers.
// The sequencer takes the slave side; the environment takes master.
interface reg_sort_sequencer_if #(
   parameter int WIDTH = 6
);
   logic             start;
   logic [WIDTH-1:0] q1;
   logic [WIDTH-1:0] q2;
   logic [WIDTH-1:0] q3;
   logic [2:0]       ext_wr;
   logic [WIDTH-1:0] ext_d;
   logic [WIDTH-1:0] d_bus;
   logic             ena1;
   logic             ena2;
   logic             ena3;
   logic             busy;
   logic             ext_grant;
   logic             done;
   logic [1:0]       swap_count;

   modport master (
      output start, q1, q2, q3, ext_wr, ext_d,
      input  d_bus, ena1, ena2, ena3,
      input  busy, ext_grant, done, swap_count
   );

   modport slave (
      input  start, q1, q2, q3, ext_wr, ext_d,
      output d_bus, ena1, ena2, ena3,
      output busy, ext_grant, done, swap_count
   );
endinterface

// File: rtl/reg_sort_sequencer.sv
// Shares one write bus among three registers and sorts them in place
// with a three-step compare-and-swap network (pairs 1-2, 2-3, 1-2).
module reg_sort_sequencer #(
   parameter int WIDTH      = 6,
   parameter bit DESCENDING = 1'b0
) (
   input logic                 ck,
   input logic                 rst,
   reg_sort_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      CMP,
      WA,
      WB,
      FIN
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       p_q, p_d;
   logic [1:0]       swaps_q, swaps_d;
   logic [WIDTH-1:0] tmp_q, tmp_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] qa;
   logic [WIDTH-1:0] qb;
   logic             swap_c;
   logic             last_pair;

   // p=1 is the (2,3) pair; p=0 and p=2 both use (1,2)
   always_comb begin
      qa = bus.q1;
      qb = bus.q2;
      if (p_q == 2'd1) begin
         qa = bus.q2;
         qb = bus.q3;
      end
   end

   assign swap_c    = DESCENDING ? (qa < qb) : (qa > qb);
   assign last_pair = (p_q == 2'd2);

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      swaps_d = swaps_q;
      tmp_d   = tmp_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               p_d     = 2'd0;
               swaps_d = 2'd0;
               state_d = CMP;
            end
         end
         CMP: begin
            if (swap_c) begin
               tmp_d   = qa;
               state_d = WA;
            end else if (last_pair) begin
               state_d = FIN;
            end else begin
               p_d = p_q + 2'd1;
            end
         end
         WA: begin
            state_d = WB;
         end
         WB: begin
            swaps_d = swaps_q + 2'd1;
            if (last_pair) begin
               state_d = FIN;
            end else begin
               p_d     = p_q + 2'd1;
               state_d = CMP;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == FIN);
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         p_q     <= 2'd0;
         swaps_q <= 2'd0;
         tmp_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         swaps_q <= swaps_d;
         tmp_q   <= tmp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Bus ownership: external pass-through only in IDLE
   always_comb begin
      bus.d_bus = '0;
      bus.ena1  = 1'b0;
      bus.ena2  = 1'b0;
      bus.ena3  = 1'b0;
      case (state_q)
         IDLE: begin
            bus.d_bus = bus.ext_d;
            bus.ena1  = bus.ext_wr[0];
            bus.ena2  = bus.ext_wr[1];
            bus.ena3  = bus.ext_wr[2];
         end
         WA: begin
            bus.d_bus = qb;
            if (p_q == 2'd1) begin
               bus.ena2 = 1'b1;
            end else begin
               bus.ena1 = 1'b1;
            end
         end
         WB: begin
            bus.d_bus = tmp_q;
            if (p_q == 2'd1) begin
               bus.ena3 = 1'b1;
            end else begin
               bus.ena2 = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   assign bus.busy       = busy_q;
   assign bus.ext_grant  = ~busy_q;
   assign bus.done       = done_q;
   assign bus.swap_count = swaps_q;

endmodule

// File: tb/tb_reg_sort_sequencer.sv
// Bench: ascending and descending sequencers side by side, each with
// its own three behavioural registers, checked against a scoreboard.
module tb_reg_sort_sequencer;

   localparam int W = 6;

   typedef struct {
      logic [W-1:0] q1;
      logic [W-1:0] q2;
      logic [W-1:0] q3;
      int           sw;
      int           lat;
   } exp_t;

   logic         ck = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   ext_wr = 3'b000;
   logic [W-1:0] ext_d = '0;

   logic [W-1:0] ra[3] = '{default: '0};
   logic [W-1:0] rb[3] = '{default: '0};

   exp_t exp_a[$];
   exp_t exp_b[$];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 ck = ~ck;

   reg_sort_sequencer_if #(.WIDTH(W)) ba ();
   reg_sort_sequencer_if #(.WIDTH(W)) bb ();

   assign ba.start  = start;
   assign ba.ext_wr = ext_wr;
   assign ba.ext_d  = ext_d;
   assign ba.q1     = ra[0];
   assign ba.q2     = ra[1];
   assign ba.q3     = ra[2];
   assign bb.start  = start;
   assign bb.ext_wr = ext_wr;
   assign bb.ext_d  = ext_d;
   assign bb.q1     = rb[0];
   assign bb.q2     = rb[1];
   assign bb.q3     = rb[2];

   reg_sort_sequencer #(.WIDTH(W), .DESCENDING(1'b0)) dut_a (
      .ck(ck), .rst(rst), .bus(ba.slave)
   );

   reg_sort_sequencer #(.WIDTH(W), .DESCENDING(1'b1)) dut_b (
      .ck(ck), .rst(rst), .bus(bb.slave)
   );

   // Enable-loaded registers without reset
   always @(posedge ck) begin
      if (ba.ena1) ra[0] <= ba.d_bus;
      if (ba.ena2) ra[1] <= ba.d_bus;
      if (ba.ena3) ra[2] <= ba.d_bus;
      if (bb.ena1) rb[0] <= bb.d_bus;
      if (bb.ena2) rb[1] <= bb.d_bus;
      if (bb.ena3) rb[2] <= bb.d_bus;
   end

   function automatic exp_t model(input bit desc,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  input logic [W-1:0] c);
      logic [W-1:0] v[3];
      logic [W-1:0] t;
      int           pi[3];
      int           s;
      bit           sw;
      exp_t         e;
      v = '{a, b, c};
      pi = '{0, 1, 0};
      s = 0;
      for (int k = 0; k < 3; k++) begin
         sw = desc ? (v[pi[k]] < v[pi[k]+1]) : (v[pi[k]] > v[pi[k]+1]);
         if (sw) begin
            t = v[pi[k]];
            v[pi[k]] = v[pi[k]+1];
            v[pi[k]+1] = t;
            s++;
         end
      end
      e.q1 = v[0];
      e.q2 = v[1];
      e.q3 = v[2];
      e.sw = s;
      e.lat = 4 + 2 * s;
      return e;
   endfunction

   task automatic wr(input logic [2:0] m, input logic [W-1:0] d);
      @(negedge ck);
      ext_wr = m;
      ext_d  = d;
      @(negedge ck);
      ext_wr = 3'b000;
   endtask

   task automatic load(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [W-1:0] c);
      wr(3'b001, a);
      wr(3'b010, b);
      wr(3'b100, c);
   endtask

   task automatic push(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [W-1:0] c);
      exp_a.push_back(model(1'b0, a, b, c));
      exp_b.push_back(model(1'b1, a, b, c));
   endtask

   task automatic run_check(input string tag, input bit hold);
      bit           seen[2];
      int           enas[2];
      int           cnt;
      exp_t         e;
      logic [W-1:0] qv[2][3];
      logic         dn[2];
      logic [1:0]   sc[2];
      logic [2:0]   en[2];
      seen = '{0, 0};
      enas = '{0, 0};
      @(negedge ck);
      start = 1'b1;
      @(negedge ck);
      start = 1'b0;
      if (hold) begin
         ext_wr = 3'b001;
         ext_d  = 6'd7;
      end
      for (int n = 1; n <= 24; n++) begin
         if (n > 1) @(negedge ck);
         en[0] = {ba.ena3, ba.ena2, ba.ena1};
         en[1] = {bb.ena3, bb.ena2, bb.ena1};
         dn[0] = ba.done;
         dn[1] = bb.done;
         sc[0] = ba.swap_count;
         sc[1] = bb.swap_count;
         qv[0] = '{ra[0], ra[1], ra[2]};
         qv[1] = '{rb[0], rb[1], rb[2]};
         for (int d = 0; d < 2; d++) begin
            if (seen[d]) continue;
            cnt = $countones(en[d]);
            enas[d] += cnt;
            n_cmp++;
            if (cnt > 1) begin
               n_bad++;
               $display("FAIL %s_onehot dut%0d cyc%0d: ena=%b, required at most one high",
                        tag, d, n, en[d]);
            end
            if (dn[d]) begin
               seen[d] = 1'b1;
               if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL %s_spurious dut%0d: done with empty scoreboard", tag, d);
               end else begin
                  if (d == 0) e = exp_a.pop_front();
                  else e = exp_b.pop_front();
                  n_cmp++;
                  if (n !== e.lat) begin
                     n_bad++;
                     $display("FAIL %s_latency dut%0d: done in cycle %0d, required %0d",
                              tag, d, n, e.lat);
                  end
                  n_cmp++;
                  if (int'(sc[d]) !== e.sw) begin
                     n_bad++;
                     $display("FAIL %s_swaps dut%0d: swap_count=%0d, required %0d",
                              tag, d, sc[d], e.sw);
                  end
                  n_cmp++;
                  if (enas[d] !== 2 * e.sw) begin
                     n_bad++;
                     $display("FAIL %s_enas dut%0d: %0d enable pulses, required %0d",
                              tag, d, enas[d], 2 * e.sw);
                  end
                  n_cmp++;
                  if (qv[d][0] !== e.q1 || qv[d][1] !== e.q2 || qv[d][2] !== e.q3) begin
                     n_bad++;
                     $display("FAIL %s_result dut%0d: q=(%0d,%0d,%0d), required (%0d,%0d,%0d)",
                              tag, d, qv[d][0], qv[d][1], qv[d][2], e.q1, e.q2, e.q3);
                  end
               end
            end
         end
         if (hold && (dn[0] || dn[1])) ext_wr = 3'b000;
         if (seen[0] && seen[1]) break;
      end
      ext_wr = 3'b000;
      for (int d = 0; d < 2; d++) begin
         if (!seen[d]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout dut%0d: no done within 24 cycles, required done", tag, d);
         end
      end
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if (ba.busy !== 1'b0 || ba.done !== 1'b0 || ba.swap_count !== 2'd0 ||
          ba.ext_grant !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_a: busy=%b done=%b sc=%0d grant=%b, required 0 0 0 1",
                  ba.busy, ba.done, ba.swap_count, ba.ext_grant);
      end
      n_cmp++;
      if (bb.busy !== 1'b0 || bb.done !== 1'b0 || bb.swap_count !== 2'd0 ||
          bb.ext_grant !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_b: busy=%b done=%b sc=%0d grant=%b, required 0 0 0 1",
                  bb.busy, bb.done, bb.swap_count, bb.ext_grant);
      end
      @(negedge ck);
      rst = 1'b0;
   endtask

   task automatic test_idle_write();
      wr(3'b001, 6'd7);
      n_cmp++;
      if (ra[0] !== 6'd7 || rb[0] !== 6'd7) begin
         n_bad++;
         $display("FAIL idle_write: q1=%0d/%0d, required 7/7", ra[0], rb[0]);
      end
      wr(3'b110, 6'd9);
      n_cmp++;
      if (ra[1] !== 6'd9 || ra[2] !== 6'd9 || ra[0] !== 6'd7) begin
         n_bad++;
         $display("FAIL idle_write2: q=(%0d,%0d,%0d), required (7,9,9)", ra[0], ra[1], ra[2]);
      end
   endtask

   task automatic test_sort(input string tag,
                            input logic [W-1:0] a,
                            input logic [W-1:0] b,
                            input logic [W-1:0] c);
      load(a, b, c);
      push(a, b, c);
      run_check(tag, 1'b0);
   endtask

   task automatic test_swap_reset();
      @(negedge ck);
      n_cmp++;
      if (ba.swap_count !== 2'd3) begin
         n_bad++;
         $display("FAIL held_swaps: swap_count=%0d, required 3", ba.swap_count);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (ba.swap_count !== 2'd0 || bb.swap_count !== 2'd0) begin
         n_bad++;
         $display("FAIL async_clear: swap_count=%0d/%0d, required 0/0",
                  ba.swap_count, bb.swap_count);
      end
      @(negedge ck);
      rst = 1'b0;
   endtask

   task automatic test_busy_block();
      load(6'd10, 6'd20, 6'd30);
      push(6'd10, 6'd20, 6'd30);
      run_check("busy_block", 1'b1);
   endtask

   task automatic test_reset_wa();
      load(6'd3, 6'd2, 6'd1);
      @(negedge ck);
      start = 1'b1;
      @(negedge ck);
      start = 1'b0;
      @(negedge ck);
      n_cmp++;
      if (ba.busy !== 1'b1 || ba.ena1 !== 1'b1 || ba.d_bus !== 6'd2) begin
         n_bad++;
         $display("FAIL wa_state: busy=%b ena1=%b d_bus=%0d, required 1 1 2",
                  ba.busy, ba.ena1, ba.d_bus);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (ba.busy !== 1'b0 || ba.done !== 1'b0 || ba.ext_grant !== 1'b1 ||
          {ba.ena3, ba.ena2, ba.ena1} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_wa: busy=%b done=%b grant=%b ena=%b, required 0 0 1 000",
                  ba.busy, ba.done, ba.ext_grant, {ba.ena3, ba.ena2, ba.ena1});
      end
      @(negedge ck);
      rst = 1'b0;
      n_cmp++;
      if (ra[0] !== 6'd3 || ra[1] !== 6'd2 || ra[2] !== 6'd1) begin
         n_bad++;
         $display("FAIL reset_wa_regs: q=(%0d,%0d,%0d), required (3,2,1)", ra[0], ra[1], ra[2]);
      end
   endtask

   task automatic test_back_to_back();
      bit got;
      load(6'd1, 6'd2, 6'd3);
      @(negedge ck);
      start = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 12 && !got; n++) begin
         @(negedge ck);
         got = ba.done;
      end
      n_cmp++;
      if (!got) begin
         n_bad++;
         $display("FAIL b2b_done: no done within 12 cycles, required done");
      end
      @(negedge ck);
      n_cmp++;
      if (ba.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_idle: busy=%b, required 0", ba.busy);
      end
      @(negedge ck);
      n_cmp++;
      if (ba.busy !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_retrigger: busy=%b, required 1", ba.busy);
      end
      start = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge ck);
         got = !ba.busy && !bb.busy;
      end
      n_cmp++;
      if (!got || ba.swap_count !== 2'd0 || bb.swap_count !== 2'd3) begin
         n_bad++;
         $display("FAIL b2b_end: idle=%b sc=%0d/%0d, required 1 0/3",
                  got, ba.swap_count, bb.swap_count);
      end
   endtask

   initial begin
      test_reset();
      test_idle_write();
      test_sort("sorted", 6'd1, 6'd2, 6'd3);
      test_sort("reversed", 6'd3, 6'd2, 6'd1);
      test_swap_reset();
      test_sort("ties", 6'd5, 6'd5, 6'd2);
      test_sort("mixed", 6'd63, 6'd0, 6'd40);
      test_busy_block();
      test_reset_wa();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_sort_sequencer.md
# reg_sort_sequencer

Sequencer that shares a single write bus among the three 6-bit enable-loaded registers and, on command, sorts their contents in place with a 3-step compare-and-swap network. It owns the registers' `ena` lines and a common `d` bus, and reads back their `q` outputs. When idle, it forwards external write requests to the registers; while a sort runs, it blocks them.

## Interface
- `WIDTH`, 6, data width of the registers and the bus.
- `DESCENDING`, 0, sort order: 0 gives q1<=q2<=q3; 1 gives q1>=q2>=q3.

- `ck`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  sort request; sampled only in IDLE.
- `q1`, `q2`, `q3`  in  WIDTH  current register outputs.
- `ext_wr`  in  3  external write enables; bit i targets register i+1.
- `ext_d`  in  WIDTH  external write data.
- `d_bus`  out  WIDTH  shared data bus to all three registers' `d`.
- `ena1`, `ena2`, `ena3`  out  1  register load enables.
- `busy`  out  1  high in every state except IDLE.
- `ext_grant`  out  1  equals `~busy`.
- `done`  out  1  one-cycle pulse at the end of a sort.
- `swap_count`  out  2  number of swaps in the last sort; held until the next start.

## Operation
- **States:** IDLE, CMP, WA, WB, FIN. A 2-bit pair index p selects the pair: p=0 is (1,2), p=1 is (2,3), p=2 is (1,2). Call the pair's registers a and b.
- **IDLE**
  - `ena{i}` = `ext_wr[i-1]`, `d_bus` = `ext_d`; combinational pass-through.
  - If `start`=1: p<=0, `swap_count`<=0, go to CMP.
  - A simultaneous `ext_wr` write lands on the same edge; the sort sees the new value.
- **CMP**
  - Swap condition is qa>qb, or qa<qb when DESCENDING=1. Comparison is unsigned; equal values are never swapped.
  - If swapping: tmp<=qa, go to WA.
  - Otherwise: if p=2 go to FIN, else p<=p+1 and stay in CMP.
  - `ena*`=0, `d_bus`=0.
- **WA:** `d_bus`=qb, `ena_a`=1, go to WB.
- **WB**
  - `d_bus`=tmp, `ena_b`=1, `swap_count`<=`swap_count`+1.
  - Then go to FIN if p=2; otherwise p<=p+1 and return to CMP.
- **FIN:** `done`=1, go to IDLE.
- While busy, `ext_wr`, `ext_d` and `start` are ignored. Only one `ena` is high in any cycle.
- **Reset values:** state IDLE, p=0, tmp=0, `swap_count`=0, `done`=0, `busy`=0, `ext_grant`=1. Registered enables are 0 and the IDLE pass-through follows `ext_wr`.
- **Reset mid-operation:** returns to IDLE immediately and asynchronously. If reset lands between WA and WB, the a/b contents are left duplicated. The registers have no reset, and this outcome is accepted.

## Timing
- Let `start` be sampled at edge E0. CMP for p=0 occupies the cycle after E0.
- Each pair takes 1 cycle with no swap, or 3 cycles with a swap (CMP, WA, WB).
- Busy duration = 4 + 2·swaps cycles (CMP×3, FIN, 2 per swap). Range 4..10.
- `done` is high in the last busy cycle. `busy` falls at the edge that ends FIN.
- A register written in WA/WB shows its new q on the following cycle; the next CMP reads the updated value.
- `swap_count` saturates naturally: at most 3 swaps, fits in 2 bits.
- `start` held high continuously re-triggers one cycle after FIN, because it is sampled again in IDLE.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `busy`=0, `done`=0, `swap_count`=0, `ext_grant`=1 with no clock edge needed.
- **Already sorted:** q=(1,2,3), `start` pulse → no `ena` ever high, `done` in cycle 4 after E0, `swap_count`=0, q unchanged.
- **Reversed:** q=(3,2,1), `start` → 3 swaps, `done` in cycle 10, final (1,2,3), `swap_count`=3.
- **Descending:** DESCENDING=1, q=(1,2,3) → final (3,2,1), `swap_count`=3.
- **Ties:** q=(5,5,2) → sequence (5,5,2) → (5,2,5) → (2,5,5), `swap_count`=2, `done` in cycle 8.
- **Arbitration and reset:**
  - `ext_wr`=3'b001, `ext_d`=7 while busy → no write occurs.
  - The same request in IDLE → q1=7 after one edge.
  - `rst` asserted during WA → IDLE next instant, all `ena`=0.
